// File: rtl/lcd_bus_sequencer.sv
// HD44780-style 8-bit bus sequencer: power-up wait, 4-command init, and
// two-transaction character writes with timed E strobes and level acks.
module lcd_bus_sequencer #(
   parameter int unsigned POWERUP_CYCLES = 750000,
   parameter int unsigned T_SETUP        = 2,
   parameter int unsigned T_EN           = 25,
   parameter int unsigned T_HOLD         = 2,
   parameter int unsigned T_WAIT         = 2000,
   parameter int unsigned T_WAIT_LONG    = 82000,
   parameter int unsigned CNT_W          = 20
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Comenzar,
   input  logic       Mostrar,
   input  logic       Ejecutar,
   input  logic [7:0] Char,
   input  logic [6:0] Addr,
   output logic       Init,
   output logic       InitEscrito,
   output logic       DoneInit,
   output logic       CharEscrito,
   output logic       WrittenLCD,
   output logic       Busy,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_E,
   output logic [7:0] LCD_DB
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StSetup  = 3'd1;
   localparam logic [2:0] StEnable = 3'd2;
   localparam logic [2:0] StHold   = 3'd3;
   localparam logic [2:0] StWait   = 3'd4;
   localparam logic [2:0] StAck    = 3'd5;

   // SETUP runs one extra cycle so E rises T_SETUP+1 cycles after the start sample.
   localparam logic [CNT_W-1:0] SetupLast = CNT_W'(T_SETUP);
   localparam logic [CNT_W-1:0] EnLast    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] WaitLast  = CNT_W'(T_WAIT - 1);
   localparam logic [CNT_W-1:0] LongLast  = CNT_W'(T_WAIT_LONG - 1);
   localparam logic [CNT_W-1:0] PwrMax    = CNT_W'(POWERUP_CYCLES);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] pwr_q, pwr_d;
   logic [2:0]       index_q, index_d;
   logic             init_q, init_d;
   logic             init_ack_q, init_ack_d;
   logic             char_ack_q, char_ack_d;
   logic             written_q, written_d;
   logic             phase_q, phase_d;
   logic             is_char_q, is_char_d;
   logic             long_q, long_d;
   logic             e_q, e_d;
   logic             rs_q, rs_d;
   logic [7:0]       db_q, db_d;
   logic [7:0]       char_q, char_d;

   logic [2:0] mode;
   logic       exec;
   logic       done_init;
   logic       start;
   logic [7:0] rom_cmd;
   logic       nxt_rs;
   logic [7:0] nxt_db;

   assign mode      = {Comenzar, Mostrar, Ejecutar};
   assign exec      = (mode == 3'b001);
   assign done_init = (index_q == 3'd4);
   assign start     = exec && (state_q == StIdle) && !init_ack_q && !char_ack_q &&
                      ((init_q && !done_init) || done_init);

   always_comb begin
      rom_cmd = 8'h38;
      case (index_q[1:0])
         2'd0:    rom_cmd = 8'h38;
         2'd1:    rom_cmd = 8'h0C;
         2'd2:    rom_cmd = 8'h01;
         default: rom_cmd = 8'h06;
      endcase
   end

   always_comb begin
      nxt_rs = 1'b0;
      nxt_db = rom_cmd;
      if (done_init) begin
         nxt_rs = phase_q;
         nxt_db = phase_q ? char_q : {1'b1, Addr};
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      pwr_d      = pwr_q;
      index_d    = index_q;
      init_ack_d = init_ack_q;
      char_ack_d = char_ack_q;
      written_d  = written_q;
      phase_d    = phase_q;
      is_char_d  = is_char_q;
      long_d     = long_q;
      e_d        = e_q;
      rs_d       = rs_q;
      db_d       = db_q;
      char_d     = char_q;

      if (mode == 3'b100 && pwr_q != PwrMax) begin
         pwr_d = pwr_q + CNT_W'(1);
      end
      init_d = init_q | (pwr_d == PwrMax);

      if (!exec) begin
         init_ack_d = 1'b0;
         char_ack_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StSetup;
               timer_d   = '0;
               is_char_d = done_init;
               rs_d      = nxt_rs;
               db_d      = nxt_db;
               // Clear and home commands need the long execution wait.
               long_d    = !nxt_rs && (nxt_db[7:2] == 6'd0) && (nxt_db[1:0] != 2'd0);
               if (done_init && !phase_q) begin
                  char_d    = Char;
                  written_d = 1'b0;
               end
            end
         end
         StSetup: begin
            if (timer_q == SetupLast) begin
               state_d = StEnable;
               timer_d = '0;
               e_d     = 1'b1;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         StEnable: begin
            if (timer_q == EnLast) begin
               state_d = StHold;
               timer_d = '0;
               e_d     = 1'b0;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         StHold: begin
            if (timer_q == HoldLast) begin
               state_d = StWait;
               timer_d = '0;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         StWait: begin
            if (timer_q == (long_q ? LongLast : WaitLast)) begin
               state_d = StAck;
               timer_d = '0;
               if (is_char_q) begin
                  char_ack_d = 1'b1;
                  phase_d    = ~phase_q;
                  if (phase_q) begin
                     written_d = 1'b1;
                  end
               end else begin
                  init_ack_d = 1'b1;
                  index_d    = index_q + 3'd1;
               end
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         pwr_q      <= '0;
         index_q    <= 3'd0;
         init_q     <= 1'b0;
         init_ack_q <= 1'b0;
         char_ack_q <= 1'b0;
         written_q  <= 1'b0;
         phase_q    <= 1'b0;
         is_char_q  <= 1'b0;
         long_q     <= 1'b0;
         e_q        <= 1'b0;
         rs_q       <= 1'b0;
         db_q       <= 8'h00;
         char_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pwr_q      <= pwr_d;
         index_q    <= index_d;
         init_q     <= init_d;
         init_ack_q <= init_ack_d;
         char_ack_q <= char_ack_d;
         written_q  <= written_d;
         phase_q    <= phase_d;
         is_char_q  <= is_char_d;
         long_q     <= long_d;
         e_q        <= e_d;
         rs_q       <= rs_d;
         db_q       <= db_d;
         char_q     <= char_d;
      end
   end

   assign Init        = init_q;
   assign InitEscrito = init_ack_q;
   assign DoneInit    = done_init;
   assign CharEscrito = char_ack_q;
   assign WrittenLCD  = written_q;
   assign Busy        = (state_q == StSetup) || (state_q == StEnable) ||
                        (state_q == StHold) || (state_q == StWait);
   assign LCD_RS      = rs_q;
   assign LCD_RW      = 1'b0;
   assign LCD_E       = e_q;
   assign LCD_DB      = db_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: transaction table plus power-up, idle and reset sequences;
// every E strobe is matched against a queue of expected bus values.
module tb_lcd_bus_sequencer;

   localparam int unsigned PW  = 10;
   localparam int unsigned TS  = 2;
   localparam int unsigned TE  = 4;
   localparam int unsigned TH  = 2;
   localparam int unsigned TW  = 8;
   localparam int unsigned TWL = 20;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Comenzar = 1'b0, Mostrar = 1'b0, Ejecutar = 1'b0;
   logic [7:0] Char = 8'h00;
   logic [6:0] Addr = 7'h00;
   logic       Init, InitEscrito, DoneInit, CharEscrito, WrittenLCD, Busy;
   logic       LCD_RS, LCD_RW, LCD_E;
   logic [7:0] LCD_DB;

   lcd_bus_sequencer #(
      .POWERUP_CYCLES(PW), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH),
      .T_WAIT(TW), .T_WAIT_LONG(TWL), .CNT_W(20)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Comenzar(Comenzar), .Mostrar(Mostrar), .Ejecutar(Ejecutar),
      .Char(Char), .Addr(Addr), .Init(Init), .InitEscrito(InitEscrito), .DoneInit(DoneInit),
      .CharEscrito(CharEscrito), .WrittenLCD(WrittenLCD), .Busy(Busy), .LCD_RS(LCD_RS),
      .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_DB(LCD_DB)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] chr;
      logic       rs;
      logic [7:0] db;
      int         lat;
      logic       iack;
      logic       wr_start;
      logic       wr;
      logic       done;
   } txn_t;

   typedef struct {
      logic       rs;
      logic [7:0] db;
   } bus_t;

   bus_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   txn_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_mode(input logic [2:0] m);
      {Comenzar, Mostrar, Ejecutar} = m;
   endtask

   // Strobe monitor: each E rise must match the next queued bus value, width T_EN.
   logic e_prev = 1'b0;
   int   e_width = 0;
   initial begin
      bus_t cur;
      forever begin
         @(negedge Clk);
         if (LCD_E && !e_prev) begin
            e_width = 1;
            check("e_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               check("e_rs", 32'(LCD_RS), 32'(cur.rs));
               check("e_db", 32'(LCD_DB), 32'(cur.db));
            end
         end else if (LCD_E) begin
            e_width++;
         end else if (e_prev && !Reset) begin
            check("e_width", 32'(e_width), 32'(TE));
         end
         e_prev = LCD_E;
      end
   end

   task automatic run_txn(input txn_t t);
      int   cnt;
      int   e_at;
      bus_t b;
      Addr = t.addr;
      Char = t.chr;
      set_mode(3'b001);
      b.rs = t.rs;
      b.db = t.db;
      exp_q.push_back(b);
      @(posedge Clk);
      @(negedge Clk);
      check("busy_start", 32'(Busy), 32'd1);
      check("written_start", 32'(WrittenLCD), 32'(t.wr_start));
      cnt  = 0;
      e_at = -1;
      while (!(InitEscrito || CharEscrito) && cnt < 200) begin
         if (LCD_E && e_at < 0) e_at = cnt;
         @(posedge Clk);
         cnt++;
         @(negedge Clk);
      end
      check("ack_latency", 32'(cnt), 32'(t.lat));
      check("e_start", 32'(e_at), 32'(TS + 1));
      check("init_ack", 32'(InitEscrito), 32'(t.iack));
      check("char_ack", 32'(CharEscrito), 32'(!t.iack));
      check("written", 32'(WrittenLCD), 32'(t.wr));
      check("done_init", 32'(DoneInit), 32'(t.done));
      repeat (3) @(negedge Clk);
      check("ack_held", 32'(InitEscrito | CharEscrito), 32'd1);
      set_mode(t.iack ? 3'b101 : 3'b011);
      @(negedge Clk);
      check("ack_clear", 32'({InitEscrito, CharEscrito}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic act;
      //          addr   chr    rs    db     lat  iack  wr0   wr    done
      tbl[0] = '{7'h00, 8'h00, 1'b0, 8'h38, 17, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{7'h00, 8'h00, 1'b0, 8'h0C, 17, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{7'h00, 8'h00, 1'b0, 8'h01, 29, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{7'h00, 8'h00, 1'b0, 8'h06, 17, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{7'h05, 8'h41, 1'b0, 8'h85, 17, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{7'h05, 8'h41, 1'b1, 8'h41, 17, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{7'h40, 8'h5A, 1'b0, 8'hC0, 17, 1'b0, 1'b0, 1'b0, 1'b1};

      set_mode(3'b000);
      repeat (3) @(negedge Clk);
      check("reset_outputs", 32'({Init, InitEscrito, DoneInit, CharEscrito, WrittenLCD, Busy,
                                 LCD_RS, LCD_RW, LCD_E, LCD_DB}), 32'd0);
      Reset = 1'b0;

      // Power-up count, interrupted by idle and a premature execute.
      set_mode(3'b100);
      repeat (6) @(negedge Clk);
      check("init_early", 32'(Init), 32'd0);
      set_mode(3'b010);
      repeat (5) @(negedge Clk);
      check("init_frozen", 32'(Init), 32'd0);
      set_mode(3'b001);
      act = 1'b0;
      repeat (5) begin
         @(negedge Clk);
         act = act | Busy | LCD_E;
      end
      check("no_start_before_init", 32'(act), 32'd0);
      set_mode(3'b100);
      for (int k = 7; k <= 12; k++) begin
         @(negedge Clk);
         check("init_rise", 32'(Init), 32'(k >= int'(PW)));
      end
      set_mode(3'b010);
      repeat (2) @(negedge Clk);
      check("init_sticky", 32'(Init), 32'd1);

      for (int i = 0; i < 7; i++) run_txn(tbl[i]);

      // Check modes with ack low must never start a transaction.
      act = 1'b0;
      set_mode(3'b101);
      repeat (25) begin
         @(negedge Clk);
         act = act | Busy | LCD_E;
      end
      set_mode(3'b011);
      repeat (25) begin
         @(negedge Clk);
         act = act | Busy | LCD_E;
      end
      check("idle_quiet", 32'(act), 32'd0);

      // Reset while E is high during the phase-1 write of 0x5A.
      begin
         bus_t b;
         b.rs = 1'b1;
         b.db = 8'h5A;
         exp_q.push_back(b);
      end
      set_mode(3'b001);
      @(posedge Clk);
      repeat (4) @(negedge Clk);
      check("e_before_reset", 32'(LCD_E), 32'd1);
      Reset = 1'b1;
      set_mode(3'b010);
      @(negedge Clk);
      check("reset_mid_outputs", 32'({Init, InitEscrito, DoneInit, CharEscrito, WrittenLCD,
                                     Busy, LCD_RS, LCD_RW, LCD_E, LCD_DB}), 32'd0);
      Reset = 1'b0;
      set_mode(3'b100);
      repeat (9) @(negedge Clk);
      check("reinit_early", 32'(Init), 32'd0);
      @(negedge Clk);
      check("reinit_rise", 32'(Init), 32'd1);
      set_mode(3'b010);
      @(negedge Clk);
      run_txn(tbl[0]);

      repeat (3) @(negedge Clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
